usb_tx_packetizer: RTL and testbench
====================================

Name: usb_tx_packetizer

Overview:
Downstream neighbour of encryptor_core, upstream of the USB transmitter's bit-level encoder (bit-stuff/NRZI). Takes one 64-bit result block via trans_data/trans_data_ready and frames it as a USB data packet: PID byte, 8 payload bytes LSB-byte-first, then CRC16 (2 bytes). Emits bytes over a valid/ready interface and pulses handshake_ack back to encryptor_core when the last byte is accepted.

Parameters:
DATA_BYTES, 8, payload bytes per packet; trans_data width = DATA_BYTES*8.
PID_DATA0, 8'hC3, DATA0 PID byte as transmitted (PID nibble plus check nibble).
PID_DATA1, 8'h4B, DATA1 PID byte as transmitted.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
trans_data_ready  input  1  request from encryptor_core; trans_data is valid while high.
trans_data  input  DATA_BYTES*8  block to send; byte 0 = bits [7:0].
handshake_ack  output  1  one-cycle pulse when the final CRC byte is accepted downstream.
busy  output  1  high from capture until handshake_ack, inclusive.
tx_byte  output  8  current byte to encoder.
tx_byte_valid  output  1  tx_byte is valid.
tx_byte_ready  input  1  encoder accepts tx_byte this cycle (transfer = valid & ready).
tx_sop  output  1  high with the PID byte.
tx_eop  output  1  high with the CRC high byte.

Behaviour:
- Reset (rst high at a clock edge): state IDLE; all outputs 0; toggle = DATA0; rearm = 1; CRC = 16'hFFFF. A reset mid-packet aborts at once. No ack is produced, and the encoder sees tx_byte_valid drop.
- States: IDLE -> PID -> DATA -> CRC_LO -> CRC_HI -> DONE -> IDLE.
- IDLE:
  - If trans_data_ready & rearm: latch trans_data into a holding register, clear rearm, load CRC = 16'hFFFF, go to PID.
  - rearm sets on any cycle trans_data_ready is low. This prevents a resend when the core holds its request level across the ack.
- PID: tx_byte = current toggle PID, tx_sop = 1, valid = 1. On transfer, go to DATA with byte index = 0.
- DATA:
  - tx_byte = holding[index*8 +: 8].
  - On transfer: update CRC over that byte, LSB-first, with reflected polynomial 16'hA001 (x^16+x^15+x^2+1). Then increment index.
  - On transfer at index = DATA_BYTES-1, go to CRC_LO. The index never wraps.
- CRC_LO: tx_byte = ~crc[7:0]. On transfer, go to CRC_HI.
- CRC_HI: tx_byte = ~crc[15:8], tx_eop = 1. On transfer, go to DONE.
- DONE: one cycle; handshake_ack = 1, valid = 0. Toggle flips (see optional feature). Go to IDLE.
- Latency: capture edge, then the PID is valid on the next cycle. With ready held high, a packet takes DATA_BYTES+3 transfer cycles, and ack follows one cycle after the CRC_HI transfer.
- Valid/ready rules:
  - While valid & !ready, tx_byte, tx_sop and tx_eop are held stable, and valid never drops, except on reset.
  - The CRC updates only on a DATA-state transfer.
- trans_data and trans_data_ready changes during busy are ignored. The holding register guarantees payload stability.
- busy = (state != IDLE).

Optional Feature:
Macro DATA_TOGGLE_EN.
- Defined: a toggle register selects PID_DATA0/PID_DATA1. It resets to DATA0 and flips in DONE after every completed packet.
- Undefined: the toggle register is not built, and every packet uses PID_DATA0.

Test Plan:
1. Reset, then trans_data_ready=1 with trans_data=64'h0706050403020100 and ready held 1 -> bytes C3,00,01,...,07,CRC_LO,CRC_HI. tx_sop is on C3 only, tx_eop on CRC_HI only, and handshake_ack pulses once, one cycle after CRC_HI.
2. Feed the 10 bytes after the PID of scenario 1 into a bench reflected CRC16 (0xA001, init FFFF) -> the register ends at residual 16'hB001. The CRC bytes also match the bench model for payload 64'h0.
3. Randomly deassert tx_byte_ready (about 50%) during a packet of 64'hDEADBEEFCAFEF00D -> the byte sequence is identical to the ready-always run, and tx_byte is stable whenever valid & !ready.
4. Hold trans_data_ready=1 continuously for 40 cycles -> exactly one packet and one ack. After trans_data_ready goes low for 1 cycle and high again, a second packet starts.
5. With DATA_TOGGLE_EN, send three back-to-back packets -> PIDs C3, 4B, C3. Without DATA_TOGGLE_EN -> C3, C3, C3.
6. Assert rst at the 4th data byte -> the next cycle has valid=0, busy=0, no ack, toggle back to DATA0. A new request then yields a full packet starting with C3.

Source files
------------

// File: rtl/usb_tx_packetizer.sv
// Frames one DATA_BYTES-wide block as a USB data packet: PID, payload LSB-byte-first, CRC16.
// Optional macro DATA_TOGGLE_EN: alternate DATA0/DATA1 PIDs on successive packets.
module usb_tx_packetizer #(
  parameter int          DATA_BYTES = 8,
  parameter logic [7:0]  PID_DATA0  = 8'hC3,
  parameter logic [7:0]  PID_DATA1  = 8'h4B
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trans_data_ready,
  input  logic [DATA_BYTES*8-1:0] trans_data,
  output logic                    handshake_ack,
  output logic                    busy,
  output logic [7:0]              tx_byte,
  output logic                    tx_byte_valid,
  input  logic                    tx_byte_ready,
  output logic                    tx_sop,
  output logic                    tx_eop
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_BYTES*8-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             crc_q, crc_d;
  logic                    rearm_q, rearm_d;
  logic                    toggle;
  logic [7:0]              data_byte;

`ifdef DATA_TOGGLE_EN
  logic toggle_q, toggle_d;
  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

  // Reflected CRC16 (poly 0xA001), one byte consumed LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign data_byte = hold_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state_d       = state_q;
    hold_d        = hold_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    rearm_d       = rearm_q | ~trans_data_ready;
`ifdef DATA_TOGGLE_EN
    toggle_d      = toggle_q;
`endif
    tx_byte       = 8'h00;
    tx_byte_valid = 1'b0;
    tx_sop        = 1'b0;
    tx_eop        = 1'b0;
    handshake_ack = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rearm blocks a second capture while the core still holds its request level.
        if (trans_data_ready && rearm_q) begin
          hold_d  = trans_data;
          rearm_d = 1'b0;
          crc_d   = 16'hFFFF;
          state_d = S_PID;
        end
      end
      S_PID: begin
        tx_byte_valid = 1'b1;
        tx_sop        = 1'b1;
        tx_byte       = toggle ? PID_DATA1 : PID_DATA0;
        if (tx_byte_ready) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_byte_valid = 1'b1;
        tx_byte       = data_byte;
        if (tx_byte_ready) begin
          crc_d = crc16_byte(crc_q, data_byte);
          if (idx_q == LAST_IDX) state_d = S_CRC_LO;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_CRC_LO: begin
        tx_byte_valid = 1'b1;
        tx_byte       = ~crc_q[7:0];
        if (tx_byte_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_byte_valid = 1'b1;
        tx_eop        = 1'b1;
        tx_byte       = ~crc_q[15:8];
        if (tx_byte_ready) state_d = S_DONE;
      end
      S_DONE: begin
        handshake_ack = 1'b1;
`ifdef DATA_TOGGLE_EN
        toggle_d      = ~toggle_q;
`endif
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      crc_q   <= 16'hFFFF;
      rearm_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      rearm_q <= rearm_d;
    end
  end

`ifdef DATA_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (rst) toggle_q <= 1'b0;
    else     toggle_q <= toggle_d;
  end
`endif

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Scoreboard bench for usb_tx_packetizer: expected bytes queued at request time, popped on each transfer.
module tb_usb_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_data_ready;
  logic [63:0] trans_data;
  logic        handshake_ack;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic        tx_sop;
  logic        tx_eop;

  always #5 clk = ~clk;

  usb_tx_packetizer dut (
    .clk              (clk),
    .rst              (rst),
    .trans_data_ready (trans_data_ready),
    .trans_data       (trans_data),
    .handshake_ack    (handshake_ack),
    .busy             (busy),
    .tx_byte          (tx_byte),
    .tx_byte_valid    (tx_byte_valid),
    .tx_byte_ready    (tx_byte_ready),
    .tx_sop           (tx_sop),
    .tx_eop           (tx_eop)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       eop;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [7:0] pkt_bytes[$];
  int   pkt_xfers    = 0;
  int   ack_cnt      = 0;
  logic ack_exp_next = 1'b0;
  logic stall_q      = 1'b0;
  logic [9:0] stall_val = '0;
  logic rand_rdy     = 1'b0;
  logic tgl          = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  // Output monitor: scoreboard pops, stall stability, ack timing, CRC residual.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] r;
    if (rst) begin
      ack_exp_next = 1'b0;
      stall_q      = 1'b0;
      pkt_xfers    = 0;
      pkt_bytes.delete();
    end else begin
      check("ack", 32'(handshake_ack), 32'(ack_exp_next));
      if (handshake_ack) ack_cnt++;
      ack_exp_next = 1'b0;
      if (stall_q) begin
        check("stall_valid", 32'(tx_byte_valid), 32'd1);
        check("stall_hold", 32'({tx_byte, tx_sop, tx_eop}), 32'(stall_val));
      end
      stall_q   = tx_byte_valid && !tx_byte_ready;
      stall_val = {tx_byte, tx_sop, tx_eop};
      if (tx_byte_valid && tx_byte_ready) begin
        pkt_xfers++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(tx_byte), 32'(e.b));
          check("sop", 32'(tx_sop), 32'(e.sop));
          check("eop", 32'(tx_eop), 32'(e.eop));
        end
        if (!tx_sop) pkt_bytes.push_back(tx_byte);
        if (tx_eop) begin
          r = 16'hFFFF;
          foreach (pkt_bytes[i]) r = crc_upd(r, pkt_bytes[i]);
          check("residual", 32'(r), 32'h0000B001);
          check("pkt_len", 32'(pkt_bytes.size()), 32'd10);
          pkt_bytes.delete();
          pkt_xfers    = 0;
          ack_exp_next = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_packet(input logic [63:0] d);
    logic [15:0] c;
    exp_q.push_back('{b: (tgl ? 8'h4B : 8'hC3), sop: 1'b1, eop: 1'b0});
    c = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{b: d[i*8 +: 8], sop: 1'b0, eop: 1'b0});
      c = crc_upd(c, d[i*8 +: 8]);
    end
    exp_q.push_back('{b: ~c[7:0],  sop: 1'b0, eop: 1'b0});
    exp_q.push_back('{b: ~c[15:8], sop: 1'b0, eop: 1'b1});
  endtask

  task automatic model_done();
`ifdef DATA_TOGGLE_EN
    tgl = ~tgl;
`endif
  endtask

  task automatic wait_ack(input int start);
    for (int i = 0; i < 300 && ack_cnt == start; i++) tick();
    check("ack_seen", 32'(ack_cnt - start), 32'd1);
    model_done();
  endtask

  task automatic send_packet(input logic [63:0] d);
    int start;
    start = ack_cnt;
    push_packet(d);
    trans_data_ready = 1'b1;
    trans_data       = d;
    tick();
    trans_data_ready = 1'b0;
    trans_data       = {$urandom, $urandom};
    check("pid_latency_valid", 32'(tx_byte_valid), 32'd1);
    check("pid_latency_sop", 32'(tx_sop), 32'd1);
    check("busy_after_capture", 32'(busy), 32'd1);
    wait_ack(start);
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst              = 1'b1;
    trans_data_ready = 1'b0;
    trans_data       = '0;
    tx_byte_ready    = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(tx_byte_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(handshake_ack), 32'd0);
    check("rst_sop", 32'(tx_sop), 32'd0);
    check("rst_eop", 32'(tx_eop), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'd0);
    rst = 1'b0;
    tick();

    // Ordered payload, then zero payload, with ready held high.
    send_packet(64'h0706050403020100);
    send_packet(64'h0);

    // Random backpressure.
    rand_rdy = 1'b1;
    send_packet(64'hDEADBEEFCAFEF00D);
    send_packet({$urandom, $urandom});
    rand_rdy = 1'b0;

    // Three back-to-back packets exercise the PID toggle.
    for (int k = 0; k < 3; k++) send_packet({$urandom, $urandom});

    // Request level held for 40 cycles yields exactly one packet.
    start = ack_cnt;
    push_packet(64'h1122334455667788);
    trans_data_ready = 1'b1;
    trans_data       = 64'h1122334455667788;
    repeat (40) tick();
    check("held_req_one_ack", 32'(ack_cnt - start), 32'd1);
    check("held_req_no_resend", 32'(busy), 32'd0);
    model_done();
    trans_data_ready = 1'b0;
    tick();
    send_packet(64'h8877665544332211);

    // Mid-packet reset at the 4th data byte.
    send_packet(64'h0F0E0D0C0B0A0908);
    start = ack_cnt;
    push_packet(64'hA5A5A5A55A5A5A5A);
    trans_data_ready = 1'b1;
    trans_data       = 64'hA5A5A5A55A5A5A5A;
    tick();
    trans_data_ready = 1'b0;
    for (int i = 0; i < 50 && pkt_xfers < 4; i++) tick();
    check("reach_data3", 32'(pkt_xfers), 32'd4);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("abort_valid", 32'(tx_byte_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(handshake_ack), 32'd0);
    rst = 1'b0;
    tgl = 1'b0;
    tick();
    check("abort_no_ack", 32'(ack_cnt - start), 32'd0);
    send_packet(64'h0123456789ABCDEF);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
